// File: rtl/display_board_ram_if.sv
// Command, status, read-port and score bundle between game logic / LED scanner and the board RAM.
// The master side is the game logic plus scanner; the slave side is the board RAM itself.
interface display_board_ram_if #(
  parameter int ADDR_W  = 6,
  parameter int COUNT_W = ADDR_W + 1
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [1:0]         cmd_data;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  disp_rd_addr;
  logic [1:0]         disp_rd_data;
  logic [ADDR_W-1:0]  game_rd_addr;
  logic [1:0]         game_rd_data;
  logic [COUNT_W-1:0] red_count;
  logic [COUNT_W-1:0] green_count;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, disp_rd_addr, game_rd_addr,
    input  cmd_ready, busy, done, disp_rd_data, game_rd_data, red_count, green_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, disp_rd_addr, game_rd_addr,
    output cmd_ready, busy, done, disp_rd_data, game_rd_data, red_count, green_count
  );
endinterface

// File: rtl/display_board_ram.sv
// 2-bit-per-cell board memory for the LED matrix: two combinational read ports,
// single-cell writes, CLEAR/FILL sweeps and live red/green stone counts.
module display_board_ram #(
  parameter int ADDR_W  = 6,
  parameter int COUNT_W = ADDR_W + 1
) (
  input  logic clk,
  input  logic rst_n_,
  display_board_ram_if.slave bus
);
  localparam int CELLS = 1 << ADDR_W;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SWEEP = 1'b1;

  // Flop array rather than block RAM: reset must clear every cell and both reads are combinational.
  logic [1:0]         mem_reg [CELLS];
  logic [0:0]         state_reg;
  logic [ADDR_W-1:0]  ptr_reg;
  logic [1:0]         fill_reg;
  logic               done_reg;
  logic [COUNT_W-1:0] red_reg;
  logic [COUNT_W-1:0] green_reg;

  logic               accept;
  logic               start_sweep;
  logic               sweep_last;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [1:0]         wr_val;
  logic [1:0]         old_val;
  logic [COUNT_W-1:0] red_next;
  logic [COUNT_W-1:0] green_next;

  assign accept      = bus.cmd_valid && (state_reg == ST_IDLE);
  assign start_sweep = accept && ((bus.cmd_op == OP_CLEAR) || (bus.cmd_op == OP_FILL));
  assign sweep_last  = (state_reg == ST_SWEEP) && (ptr_reg == ADDR_W'(CELLS - 1));

  // One shared write path: the sweep owns it while busy, otherwise an accepted WRITE does.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = bus.cmd_addr;
    wr_val  = bus.cmd_data;
    if (state_reg == ST_SWEEP) begin
      wr_en   = 1'b1;
      wr_addr = ptr_reg;
      wr_val  = fill_reg;
    end else if (accept && (bus.cmd_op == OP_WRITE)) begin
      wr_en = 1'b1;
    end
  end

  assign old_val    = mem_reg[wr_addr];
  assign red_next   = red_reg   + COUNT_W'(wr_val[1]) - COUNT_W'(old_val[1]);
  assign green_next = green_reg + COUNT_W'(wr_val[0]) - COUNT_W'(old_val[0]);

  always_ff @(posedge clk or negedge rst_n_) begin
    if (!rst_n_) begin
      for (int i = 0; i < CELLS; i++) begin
        mem_reg[i] <= 2'b00;
      end
    end else if (wr_en) begin
      mem_reg[wr_addr] <= wr_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n_) begin
    if (!rst_n_) begin
      red_reg   <= '0;
      green_reg <= '0;
    end else if (wr_en) begin
      red_reg   <= red_next;
      green_reg <= green_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n_) begin
    if (!rst_n_) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      fill_reg  <= 2'b00;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= sweep_last;
      if (state_reg == ST_IDLE) begin
        if (start_sweep) begin
          state_reg <= ST_SWEEP;
          ptr_reg   <= '0;
          fill_reg  <= (bus.cmd_op == OP_FILL) ? bus.cmd_data : 2'b00;
        end
      end else begin
        ptr_reg <= ptr_reg + ADDR_W'(1);
        if (sweep_last) begin
          state_reg <= ST_IDLE;
        end
      end
    end
  end

  assign bus.cmd_ready    = (state_reg == ST_IDLE);
  assign bus.busy         = (state_reg == ST_SWEEP);
  assign bus.done         = done_reg;
  assign bus.disp_rd_data = mem_reg[bus.disp_rd_addr];
  assign bus.game_rd_data = mem_reg[bus.game_rd_addr];
  assign bus.red_count    = red_reg;
  assign bus.green_count  = green_reg;
endmodule

// File: tb/tb_display_board_ram.sv
// Directed + random stimulus for display_board_ram, checked against a plain array model of the board.
module tb_display_board_ram;
  localparam int AW = 6;
  localparam int N  = 64;
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_FILL  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  logic clk = 1'b0;
  logic rst_n_;
  int   errors = 0;
  int   checks = 0;
  logic [1:0] model [N];

  display_board_ram_if #(.ADDR_W(AW)) bus ();

  display_board_ram #(.ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n_ (rst_n_),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Stone count of the model: number of cells with the given bit set.
  function automatic int stones(input int b);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'(model[i][b]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, " red_count"},   32'(bus.red_count),   32'(stones(1)));
    chk({tag, " green_count"}, 32'(bus.green_count), 32'(stones(0)));
  endtask

  task automatic chk_board(input string tag);
    for (int a = 0; a < N; a++) begin
      bus.disp_rd_addr = AW'(a);
      bus.game_rd_addr = AW'(N - 1 - a);
      #1;
      chk($sformatf("%s disp[%0d]", tag, a), 32'(bus.disp_rd_data), 32'(model[a]));
      chk($sformatf("%s game[%0d]", tag, N - 1 - a), 32'(bus.game_rd_data), 32'(model[N - 1 - a]));
    end
  endtask

  // Leaves cmd_valid high so consecutive calls form back-to-back writes.
  task automatic do_write(input logic [AW-1:0] a, input logic [1:0] d, input string tag);
    bus.cmd_valid    = 1'b1;
    bus.cmd_op       = OP_WRITE;
    bus.cmd_addr     = a;
    bus.cmd_data     = d;
    bus.disp_rd_addr = a;
    bus.game_rd_addr = a;
    #1;
    chk({tag, " ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, " pre-edge disp"}, 32'(bus.disp_rd_data), 32'(model[a]));
    tick();
    model[a] = d;
    chk({tag, " disp"}, 32'(bus.disp_rd_data), 32'(d));
    chk({tag, " game"}, 32'(bus.game_rd_data), 32'(d));
    chk({tag, " done"}, 32'(bus.done), 32'd0);
    chk_counts(tag);
    $display("WRITE addr=%0d data=%b red=%0d green=%0d", a, d, bus.red_count, bus.green_count);
  endtask

  task automatic run_sweep(input logic [1:0] opc, input logic [1:0] d, input int abort_at,
                           input bit hold_write, input string tag);
    logic [1:0] fillv;
    fillv = (opc == OP_FILL) ? d : 2'b00;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = opc;
    bus.cmd_data  = d;
    tick();
    if (hold_write) begin
      bus.cmd_op   = OP_WRITE;
      bus.cmd_addr = AW'(3);
      bus.cmd_data = 2'b11;
    end else begin
      bus.cmd_valid = 1'b0;
    end
    chk_counts({tag, " accept"});
    for (int k = 0; k < N; k++) begin
      if (k == abort_at) begin
        rst_n_ = 1'b0;
        #1;
        for (int i = 0; i < N; i++) model[i] = 2'b00;
        chk({tag, " abort busy"},  32'(bus.busy),      32'd0);
        chk({tag, " abort ready"}, 32'(bus.cmd_ready), 32'd1);
        chk({tag, " abort done"},  32'(bus.done),      32'd0);
        chk_counts({tag, " abort"});
        $display("SWEEP op=%b data=%b aborted by reset after %0d cells", opc, d, k);
        return;
      end
      chk($sformatf("%s busy@%0d", tag, k),  32'(bus.busy),      32'd1);
      chk($sformatf("%s ready@%0d", tag, k), 32'(bus.cmd_ready), 32'd0);
      chk($sformatf("%s done@%0d", tag, k),  32'(bus.done),      32'd0);
      tick();
      model[k] = fillv;
      chk_counts($sformatf("%s cell%0d", tag, k));
    end
    chk({tag, " end busy"},  32'(bus.busy),      32'd0);
    chk({tag, " end ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, " end done"},  32'(bus.done),      32'd1);
    tick();
    if (hold_write) begin
      model[3] = 2'b11;
      bus.cmd_valid    = 1'b0;
      bus.disp_rd_addr = AW'(3);
      #1;
      chk({tag, " held write cell3"}, 32'(bus.disp_rd_data), 32'(model[3]));
    end
    chk({tag, " done drop"}, 32'(bus.done), 32'd0);
    chk_counts({tag, " after"});
    $display("SWEEP op=%b data=%b complete red=%0d green=%0d", opc, d, bus.red_count, bus.green_count);
  endtask

  initial begin
    rst_n_           = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = OP_NOP;
    bus.cmd_addr     = '0;
    bus.cmd_data     = 2'b00;
    bus.disp_rd_addr = '0;
    bus.game_rd_addr = '0;
    for (int i = 0; i < N; i++) model[i] = 2'b00;

    repeat (3) tick();
    chk("reset ready", 32'(bus.cmd_ready), 32'd1);
    chk("reset busy",  32'(bus.busy),      32'd0);
    chk("reset done",  32'(bus.done),      32'd0);
    chk_counts("reset");
    chk_board("reset");
    tick();
    rst_n_ = 1'b1;
    tick();

    do_write(AW'(9), 2'b10, "b2b first");
    do_write(AW'(9), 2'b01, "b2b second");
    do_write(AW'(5), 2'b01, "same-cycle rw");
    bus.cmd_op = OP_NOP;
    tick();
    bus.cmd_valid = 1'b0;
    chk("nop ready", 32'(bus.cmd_ready), 32'd1);
    chk("nop done",  32'(bus.done),      32'd0);
    chk_counts("nop");

    for (int t = 0; t < 40; t++) begin
      do_write(AW'($urandom_range(N - 1)), 2'($urandom_range(3)), $sformatf("rand%0d", t));
    end
    bus.cmd_valid = 1'b0;
    tick();

    run_sweep(OP_FILL, 2'b11, -1, 1'b0, "fill11");
    chk_board("after fill");
    run_sweep(OP_CLEAR, 2'b10, -1, 1'b1, "clear");
    chk_board("after clear");

    for (int t = 0; t < 10; t++) begin
      do_write(AW'($urandom_range(N - 1)), 2'($urandom_range(3)), $sformatf("rand2_%0d", t));
    end
    bus.cmd_valid = 1'b0;
    tick();
    run_sweep(OP_FILL, 2'($urandom_range(3)), -1, 1'b0, "fillrand");

    run_sweep(OP_FILL, 2'b10, 30, 1'b0, "abort");
    repeat (2) tick();
    chk("in reset done", 32'(bus.done), 32'd0);
    chk("in reset busy", 32'(bus.busy), 32'd0);
    rst_n_ = 1'b1;
    tick();
    chk("post abort done", 32'(bus.done), 32'd0);
    chk_board("post abort");
    do_write(AW'(42), 2'b10, "post abort write");
    bus.cmd_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/display_board_ram.md
Name: display_board_ram

Overview:
- Board-state memory for the 8x8 LED display: 2^ADDR_W cells, 2 bits each. Bit 1 = red stone, bit 0 = green stone.
- Sits directly upstream of the LED matrix scanner, which reads it through a combinational read port. The scanner samples data in the same clk cycle it drives the address.
- Game logic writes through a valid/ready command port: single-cell writes, plus whole-board CLEAR/FILL sweeps.
- Maintains live red/green stone counts for scoring.

Parameters:
ADDR_W, 6, cell address width; number of cells = 2^ADDR_W (64 for 8x8 board)
COUNT_W, ADDR_W+1, stone counter width (holds 0..2^ADDR_W)

Ports:
clk  input  1  system clock
rst_n_  input  1  reset, asynchronous, active-low
cmd_valid  input  1  command request
cmd_ready  output  1  block can accept a command this cycle
cmd_op  input  2  00=WRITE, 01=CLEAR, 10=FILL, 11=NOP
cmd_addr  input  ADDR_W  target cell for WRITE
cmd_data  input  2  cell value for WRITE/FILL
busy  output  1  sweep in progress
done  output  1  one-cycle pulse at end of CLEAR/FILL sweep
disp_rd_addr  input  ADDR_W  scanner read address ({row, bit})
disp_rd_data  output  2  combinational cell value at disp_rd_addr
game_rd_addr  input  ADDR_W  game-logic read address
game_rd_data  output  2  combinational cell value at game_rd_addr
red_count  output  COUNT_W  number of cells with bit 1 set
green_count  output  COUNT_W  number of cells with bit 0 set

Behaviour:
- Reset (async, rst_n_ low):
  - all cells = 2'b00
  - FSM = IDLE; cmd_ready=1, busy=0, done=0
  - red_count=0, green_count=0
- Read ports:
  - purely combinational, no latency
  - a value written on edge N is visible on both ports right after edge N
  - read and write to the same address in the same cycle: read returns the old value until the edge
- Handshake:
  - a command is accepted on any rising edge where cmd_valid && cmd_ready
  - cmd_ready = (state == IDLE)
- FSM states: IDLE, SWEEP.
- IDLE, WRITE accepted:
  - cell[cmd_addr] <= cmd_data on the accept edge
  - stay in IDLE; back-to-back writes allowed every cycle
- IDLE, CLEAR or FILL accepted:
  - latch fill value (00 for CLEAR, cmd_data for FILL)
  - sweep pointer <= 0; go to SWEEP
  - no cell is written on the accept edge
- IDLE, NOP accepted: no state change, no effect.
- SWEEP:
  - busy=1, cmd_ready=0
  - each cycle writes fill value to cell[ptr], then ptr++
  - on the edge writing cell 2^ADDR_W-1: return to IDLE and assert done for the following cycle
  - sweep takes exactly 2^ADDR_W cycles
  - cmd_valid is ignored while in SWEEP
- Counters, updated on the same edge as every cell write (WRITE or sweep):
  - red_count <= red_count - old[1] + new[1]
  - green_count <= green_count - old[0] + new[0]
  - writing an identical value leaves counts unchanged
  - value 2'b11 is legal and counts in both
  - counts never exceed 2^ADDR_W and never underflow
  - width is COUNT_W, so 64 is representable
- done: exactly one cycle high per completed sweep; never asserted for WRITE or NOP.
- Reset mid-sweep: immediately aborts; all state returns to reset values.

Test Plan:
- Reset, then read all 64 addresses on both ports -> all 2'b00; red_count=0, green_count=0, cmd_ready=1, busy=0.
- WRITE addr 9 = 2'b10, then WRITE addr 9 = 2'b01 on the next cycle, back-to-back -> disp_rd_data at 9 is 10, then 01 after the respective edges; red_count 1 then 0; green_count 0 then 1; cmd_ready stays 1 throughout.
- FILL data 2'b11 -> cmd_ready=0 and busy=1 for exactly 64 cycles; done high for 1 cycle; red_count=green_count=64; every cell reads 11.
- After the FILL, CLEAR -> counts decrement by 1 per cycle from 64 to 0; done pulses once; cmd_valid+WRITE held during the sweep is not accepted until cmd_ready returns.
- Same-cycle read/write: disp_rd_addr=5, WRITE addr 5 = 2'b01 -> disp_rd_data=00 before the edge, 01 after.
- Assert rst_n_ low at sweep cycle 30 of a FILL 2'b10 -> all cells 00, counts 0, busy=0, no done pulse; a subsequent WRITE is accepted normally.
